lc3_reg_scoreboard: RTL

//  Scoreboard and issue controller for the 8x16 LC3 register file and the NZP condition codes.

---
 rtl/lc3_pkg.sv | 17 +
 rtl/lc3_sb_counter.sv | 41 ++++
 rtl/lc3_reg_scoreboard.sv | 85 ++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared constants and types for the LC3 register/CC scoreboard.
// Resources 0..7 are R0-R7; resource 8 is the NZP condition codes.
package lc3_pkg;

  localparam int NUM_RES = 9;
  localparam int RES_CC  = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [3:0]       res_idx_t;
  typedef logic [CNT_W-1:0] sb_cnt_t;

  function automatic res_idx_t reg2res(input logic [2:0] r);
    return {1'b0, r};
  endfunction

endpackage

// File: rtl/lc3_sb_counter.sv
// Pending-write counter for one scoreboard resource.
// Saturates at both ends; underflow flags a retire with nothing pending.
module lc3_sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         nz,
  output logic         at_max,
  output logic         underflow
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt       = cnt_q;
  assign nz        = |cnt_q;
  assign at_max    = &cnt_q;
  assign underflow = dec & ~inc & ~nz & ~clr;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc & ~dec & ~at_max)
      cnt_d = cnt_q + W'(1);
    else if (dec & ~inc & nz)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lc3_reg_scoreboard.sv
// Issue controller: stalls decode while any source has writes in flight.
// No forwarding; sources unstall the cycle after their final retire.
module lc3_reg_scoreboard #(
  parameter int NUM_REG = 8,
  parameter int CNT_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [2:0]       dec_sr1,
  input  logic             dec_sr1_use,
  input  logic [2:0]       dec_sr2,
  input  logic             dec_sr2_use,
  input  logic             dec_cc_use,
  input  logic [2:0]       dec_dr,
  input  logic             dec_dr_wr,
  input  logic             dec_cc_wr,
  input  logic             wb_valid,
  input  logic [2:0]       wb_dr,
  input  logic             wb_dr_wr,
  input  logic             wb_cc_wr,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic [NUM_REG:0] busy_vec,
  output logic             err
);

  import lc3_pkg::*;

  localparam int NRES = NUM_REG + 1;

  logic [NRES-1:0] nz, at_max, uflow, inc, dec;
  logic            hazard, full, retire;
  logic            err_q, err_d;

  assign retire = wb_valid & ~flush;

  for (genvar k = 0; k < NUM_REG; k++) begin : g_reg
    assign inc[k] = issue & dec_dr_wr
                  & (reg2res(dec_dr) == res_idx_t'(k));
    assign dec[k] = retire & wb_dr_wr
                  & (reg2res(wb_dr) == res_idx_t'(k));
  end

  assign inc[NUM_REG] = issue & dec_cc_wr;
  assign dec[NUM_REG] = retire & wb_cc_wr;

  for (genvar k = 0; k < NRES; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt_unused;
    lc3_sb_counter #(.W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc[k]),
      .dec       (dec[k]),
      .clr       (flush),
      .cnt       (cnt_unused),
      .nz        (nz[k]),
      .at_max    (at_max[k]),
      .underflow (uflow[k])
    );
  end

  assign hazard = (dec_sr1_use & nz[reg2res(dec_sr1)])
                | (dec_sr2_use & nz[reg2res(dec_sr2)])
                | (dec_cc_use  & nz[RES_CC]);

  assign full = (dec_dr_wr & at_max[reg2res(dec_dr)])
              | (dec_cc_wr & at_max[RES_CC]);

  assign stall    = dec_valid & (hazard | full);
  assign issue    = dec_valid & ~stall & ~flush;
  assign busy_vec = nz;
  assign err      = err_q;

  assign err_d = err_q | (|uflow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else
      err_q <= err_d;
  end

endmodule
